// File: rtl/led_pkg.sv
// Shared types and default parameter values for the multiplexed LED scan controller.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } led_state_e;

    localparam int DEF_DIGITS    = 4;
    localparam int DEF_SHOW_CYC  = 1000;
    localparam int DEF_BLANK_CYC = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Host-side load handshake of the LED scan controller: value, dots, suppression mode, strobe and ack.
interface led_scan_ctrl_if #(
    parameter int DIGITS = led_pkg::DEF_DIGITS
) ();
    logic [15:0]       num_in;
    logic [DIGITS-1:0] dot_in;
    logic              lz_en;
    logic              load;
    logic              load_ack;

    modport master (
        output num_in,
        output dot_in,
        output lz_en,
        output load,
        input  load_ack
    );

    modport slave (
        input  num_in,
        input  dot_in,
        input  lz_en,
        input  load,
        output load_ack
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed LED digit scanner: double-buffered value, frame-aligned adoption,
// blanking gap before every digit and leading-zero suppression.
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int DIGITS    = DEF_DIGITS,
    parameter int SHOW_CYC  = DEF_SHOW_CYC,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic               clk,
    input  logic               rst,
    led_scan_ctrl_if.slave     host,
    output logic [15:0]        bcd_num,
    output logic [2:0]         bcd_digit,
    input  logic [3:0]         bcd_out,
    output logic               seg_dot,
    output logic               seg_blank,
    output logic [DIGITS-1:0]  an_n,
    output logic               frame_tick
);

    localparam int              MAX_CYC  = max_int(SHOW_CYC, BLANK_CYC);
    localparam int              CW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0]   SHOW_LD  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0]   BLANK_LD = CW'(BLANK_CYC - 1);
    localparam logic [2:0]      TOP_DIG  = 3'(DIGITS - 1);

    led_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic [15:0]       r_pend_num;
    logic [DIGITS-1:0] r_pend_dot;
    logic              r_pend_v;
    logic [DIGITS-1:0] r_act_dot;
    logic              r_flag;

    logic              w_cnt_done;
    logic              w_last_show;
    logic              w_adopt;
    logic              w_suppress;
    logic [7:0]        w_sel;
    logic [7:0]        w_dot_ext;
    logic [DIGITS-1:0] w_an_show;

    assign w_cnt_done  = (r_cnt == {CW{1'b0}});
    assign w_last_show = (r_state == ST_SHOW) && w_cnt_done && (bcd_digit == 3'd0);
    assign w_adopt     = r_pend_v && ((r_state == ST_IDLE) || w_last_show);
    // The flag remembers a nonzero digit earlier in this frame, ending zero suppression.
    assign w_suppress  = host.lz_en && (bcd_digit != 3'd0) && (bcd_out == 4'd0) && !r_flag;
    assign w_sel       = 8'd1 << bcd_digit;
    assign w_dot_ext   = 8'(r_act_dot);
    assign w_an_show   = ~w_sel[DIGITS-1:0];

    // Scan state machine with all display, handshake and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= {CW{1'b0}};
            r_pend_num    <= 16'd0;
            r_pend_dot    <= {DIGITS{1'b0}};
            r_pend_v      <= 1'b0;
            r_act_dot     <= {DIGITS{1'b0}};
            r_flag        <= 1'b0;
            bcd_num       <= 16'd0;
            bcd_digit     <= 3'd0;
            seg_dot       <= 1'b0;
            seg_blank     <= 1'b1;
            an_n          <= {DIGITS{1'b1}};
            frame_tick    <= 1'b0;
            host.load_ack <= 1'b0;
        end else begin
            host.load_ack <= 1'b0;
            frame_tick    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    an_n      <= {DIGITS{1'b1}};
                    seg_blank <= 1'b1;
                    seg_dot   <= 1'b0;
                    if (r_pend_v) begin
                        r_state   <= ST_BLANK;
                        r_cnt     <= BLANK_LD;
                        bcd_digit <= TOP_DIG;
                        r_flag    <= 1'b0;
                    end else begin
                        r_cnt <= {CW{1'b0}};
                    end
                end
                ST_BLANK: begin
                    if (w_cnt_done) begin
                        r_state   <= ST_SHOW;
                        r_cnt     <= SHOW_LD;
                        an_n      <= w_an_show;
                        seg_dot   <= w_dot_ext[bcd_digit];
                        seg_blank <= w_suppress;
                        if (bcd_out != 4'd0) begin
                            r_flag <= 1'b1;
                        end else begin
                            r_flag <= r_flag;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (w_cnt_done) begin
                        r_state   <= ST_BLANK;
                        r_cnt     <= BLANK_LD;
                        an_n      <= {DIGITS{1'b1}};
                        seg_blank <= 1'b1;
                        seg_dot   <= 1'b0;
                        if (bcd_digit == 3'd0) begin
                            frame_tick <= 1'b1;
                            bcd_digit  <= TOP_DIG;
                            r_flag     <= 1'b0;
                        end else begin
                            bcd_digit <= bcd_digit - 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= {CW{1'b0}};
                    an_n      <= {DIGITS{1'b1}};
                    seg_blank <= 1'b1;
                    seg_dot   <= 1'b0;
                end
            endcase

            // Adoption reads the pre-edge pending contents; a load on this same edge stays pending.
            if (w_adopt) begin
                bcd_num       <= r_pend_num;
                r_act_dot     <= r_pend_dot;
                host.load_ack <= 1'b1;
                r_pend_v      <= 1'b0;
            end else begin
                r_pend_v <= r_pend_v;
            end

            if (host.load) begin
                r_pend_num <= host.num_in;
                r_pend_dot <= host.dot_in;
                r_pend_v   <= 1'b1;
            end else begin
                r_pend_num <= r_pend_num;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed self-checking bench for led_scan_ctrl with DIGITS=4, SHOW_CYC=4, BLANK_CYC=2.
module tb_led_scan_ctrl;

    localparam int DIG   = 4;
    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = SHOW + BLANK;
    localparam int FRAME = DIG * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_num;
    logic [2:0]  bcd_digit;
    logic [3:0]  bcd_out;
    logic        seg_dot;
    logic        seg_blank;
    logic [3:0]  an_n;
    logic        frame_tick;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    led_scan_ctrl_if #(.DIGITS(DIG)) u_if ();

    led_scan_ctrl #(
        .DIGITS    (DIG),
        .SHOW_CYC  (SHOW),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (u_if.slave),
        .bcd_num    (bcd_num),
        .bcd_digit  (bcd_digit),
        .bcd_out    (bcd_out),
        .seg_dot    (seg_dot),
        .seg_blank  (seg_blank),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    // Packed-BCD extractor model: nibble selected by the digit index.
    assign bcd_out = 4'(bcd_num >> {bcd_digit, 2'b00});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks one full frame from its first dark cycle, checking every cycle; optional loads at cycles ld_c/ld2_c.
    task automatic run_frame(input logic [15:0] num, input logic [3:0] dot, input logic [3:0] blank,
                             input logic ack0, input logic tick0,
                             input int ld_c, input logic [15:0] ld_num, input logic [3:0] ld_dot,
                             input int ld2_c, input logic [15:0] ld2_num, input logic [3:0] ld2_dot);
        for (int c = 0; c < FRAME; c++) begin
            int d;
            int ph;
            logic [3:0] exp_an;
            d  = (DIG - 1) - (c / SLOT);
            ph = c % SLOT;
            exp_an = ~(4'b0001 << d);
            chk("bcd_num", bcd_num, num);
            chk("bcd_digit", bcd_digit, d);
            chk("load_ack", u_if.load_ack, (c == 0) ? ack0 : 1'b0);
            chk("frame_tick", frame_tick, (c == 0) ? tick0 : 1'b0);
            if (ph < BLANK) begin
                chk("an_n_dark", an_n, 4'hF);
                chk("seg_blank_dark", seg_blank, 1'b1);
                chk("seg_dot_dark", seg_dot, 1'b0);
            end else begin
                chk("an_n_show", an_n, exp_an);
                chk("seg_blank_show", seg_blank, blank[d]);
                chk("seg_dot_show", seg_dot, dot[d]);
            end
            if (c == ld_c) begin
                u_if.load = 1'b1; u_if.num_in = ld_num; u_if.dot_in = ld_dot;
            end else if (c == ld2_c) begin
                u_if.load = 1'b1; u_if.num_in = ld2_num; u_if.dot_in = ld2_dot;
            end else begin
                u_if.load = 1'b0;
            end
            tick();
        end
        u_if.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        u_if.load = 1'b0; u_if.num_in = 16'h0; u_if.dot_in = 4'h0; u_if.lz_en = 1'b0;
        tick(); tick();
        chk("rst_an_n", an_n, 4'hF);
        chk("rst_seg_blank", seg_blank, 1'b1);
        chk("rst_seg_dot", seg_dot, 1'b0);
        chk("rst_bcd_num", bcd_num, 16'h0);
        chk("rst_bcd_digit", bcd_digit, 3'd0);
        chk("rst_load_ack", u_if.load_ack, 1'b0);
        chk("rst_frame_tick", frame_tick, 1'b0);
        rst = 1'b0;

        // No load: display stays dark with no pulses.
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_an_n", an_n, 4'hF);
            chk("idle_seg_blank", seg_blank, 1'b1);
            chk("idle_load_ack", u_if.load_ack, 1'b0);
            chk("idle_frame_tick", frame_tick, 1'b0);
        end

        // Load 1234: pending after one edge, adopted on the next.
        u_if.load = 1'b1; u_if.num_in = 16'h1234; u_if.dot_in = 4'b0000;
        tick();
        u_if.load = 1'b0;
        tick();
        run_frame(16'h1234, 4'b0000, 4'b0000, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        // Two mid-frame loads: current frame unchanged, latest one wins.
        run_frame(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, 5, 16'h6677, 4'b0000, 12, 16'h5555, 4'b0100);
        u_if.lz_en = 1'b1;
        // Load on the final cycle is sampled by the boundary edge and waits a full frame.
        run_frame(16'h5555, 4'b0100, 4'b0000, 1'b1, 1'b1, FRAME - 1, 16'h0042, 4'b0000, -1, 16'h0, 4'h0);
        run_frame(16'h5555, 4'b0100, 4'b0000, 1'b0, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame(16'h0042, 4'b0000, 4'b1100, 1'b1, 1'b1, 10, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
        run_frame(16'h0000, 4'b0000, 4'b1110, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Reset during SHOW of digit 2, with a simultaneous load that must be discarded.
        for (int i = 0; i < 9; i++) tick();
        chk("pre_rst_an_n", an_n, 4'b1011);
        rst = 1'b1; u_if.load = 1'b1; u_if.num_in = 16'h1111;
        tick();
        rst = 1'b0; u_if.load = 1'b0;
        chk("mid_rst_an_n", an_n, 4'hF);
        chk("mid_rst_bcd_num", bcd_num, 16'h0);
        chk("mid_rst_bcd_digit", bcd_digit, 3'd0);
        chk("mid_rst_seg_blank", seg_blank, 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_rst_an_n", an_n, 4'hF);
            chk("post_rst_load_ack", u_if.load_ack, 1'b0);
            chk("post_rst_frame_tick", frame_tick, 1'b0);
        end

        u_if.load = 1'b1; u_if.num_in = 16'h0009; u_if.dot_in = 4'b0001;
        tick();
        u_if.load = 1'b0;
        tick();
        run_frame(16'h0009, 4'b0001, 4'b1110, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SHOW_CYC, default 1000, clocks each digit is lit.
REQ-003 SHALL have parameter BLANK_CYC, default 16, all-dark clocks before each digit.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port num_in  in  16  value to display, to the BCD extractor.
REQ-007 SHALL have port dot_in  in  DIGITS  per-digit decimal point request.
REQ-008 SHALL have port lz_en  in  1  leading-zero suppression enable.
REQ-009 SHALL have port load  in  1  one-cycle strobe capturing num_in/dot_in.
REQ-010 SHALL have port load_ack  out  1  one-cycle pulse when a captured value becomes active.
REQ-011 SHALL have port bcd_num  out  16  active value, to the BCD extractor.
REQ-012 SHALL have port bcd_digit  out  3  digit index, to the BCD extractor.
REQ-013 SHALL have port bcd_out  in  4  extractor nibble for bcd_digit (combinational).
REQ-014 SHALL have port seg_dot  out  1  dot bit, to the segment encoder.
REQ-015 SHALL have port seg_blank  out  1  1 = numeral segments off.
REQ-016 SHALL have port an_n  out  DIGITS  active-low digit enables.
REQ-017 SHALL have port frame_tick  out  1  one-cycle pulse at end of each full scan.

Function
REQ-018 SHALL implement states IDLE, BLANK, SHOW; all outputs registered.
REQ-019 load SHALL write num_in/dot_in into a pending register and set pending_v; a later load before adoption overwrites it (latest wins).
REQ-020 In IDLE with pending_v=1, SHALL adopt at the next edge: active <= pending, pending_v <= 0, load_ack=1 for one cycle, bcd_digit <= DIGITS-1, enter BLANK.
REQ-021 BLANK: an_n all ones, seg_blank=1, seg_dot=0, for exactly BLANK_CYC cycles, then SHOW.
REQ-022 SHOW: an_n[bcd_digit]=0 and all other bits 1, for exactly SHOW_CYC cycles.
REQ-023 Scan order SHALL be DIGITS-1 down to 0; one frame = DIGITS*(BLANK_CYC+SHOW_CYC) cycles.
REQ-024 At end of SHOW for digit 0: frame_tick=1 for one cycle, bcd_digit <= DIGITS-1, enter BLANK; if pending_v, adopt per REQ-020 on the same edge (load_ack).
REQ-025 Values SHALL change only at frame boundaries; a mid-frame load never alters the current frame.
REQ-026 Adoption SHALL use pending contents before the edge; a load on the boundary edge remains pending for the next frame.
REQ-027 A nonzero-seen flag SHALL clear at frame start and set when a shown digit has bcd_out != 0 (values >9 count as nonzero).
REQ-028 With lz_en=1, digit d>0 SHALL show seg_blank=1 while bcd_out=0 and the flag is clear; digit 0 is never suppressed.
REQ-029 seg_dot SHALL equal active dot[bcd_digit] during SHOW, independent of suppression.
REQ-030 Phase counter width SHALL be clog2(max(SHOW_CYC,BLANK_CYC)); it reloads on every state change.

Reset
REQ-031 On rst: state IDLE, an_n all ones, bcd_num=0, bcd_digit=0, seg_blank=1, seg_dot=0, load_ack=0, frame_tick=0, counter=0, pending_v=0, flag=0.
REQ-032 rst mid-frame SHALL take effect on the next edge and discard active and pending values; display stays dark until a new load.
REQ-033 rst SHALL take priority over a simultaneous load.

Structure
REQ-034 Package led_pkg SHALL hold the state enum and default parameter values.
REQ-035 SHALL be one module with no sub-modules; the BCD extractor and segment encoder sit outside.

Verification (DIGITS=4, SHOW_CYC=4, BLANK_CYC=2)
REQ-036 Reset, no load, 100 cycles -> an_n=1111, seg_blank=1, load_ack and frame_tick never pulse.
REQ-037 load 1234 -> load_ack one cycle; digits 3,2,1,0 with bcd_out 1,2,3,4; each lit 4 cycles after 2 dark; frame_tick every 24 cycles.
REQ-038 lz_en=1, load 42 -> digits 3,2 seg_blank=1; digits 1,0 seg_blank=0. Load 0 -> only digit 0 unblanked.
REQ-039 Mid-frame load 6677, then load 5555 in the same frame -> current frame still shows 1234; next frame shows 5555; exactly one load_ack, at the boundary.
REQ-040 dot_in=0100 -> seg_dot=1 only while an_n=1011.
REQ-041 rst during SHOW of digit 2 -> next cycle an_n=1111 and IDLE; stays dark until a new load.
